// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: instruction fields, bubble word,
// opcodes seen by decode and the fetch FSM state encodings.
package pipeline_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 20;
  localparam int OPC_HI  = 19;
  localparam int OPC_LO  = 16;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0100;
  localparam logic [3:0] OP_ST  = 4'b0101;
  localparam logic [3:0] OP_BR  = 4'b1000;
  localparam logic [3:0] OP_JMP = 4'b1001;
  localparam logic [3:0] OP_NOP = 4'b1010;

  localparam logic [INSTR_W-1:0] NOP_WORD =
    {OP_NOP, {(INSTR_W-4){1'b0}}};

  localparam logic [PC_W-1:0] RESET_PC_DEF = '0;

  typedef enum logic [1:0] {
    FETCH_FILL = 2'b00,
    FETCH_RUN  = 2'b01,
    FETCH_HOLD = 2'b10
  } fetch_state_t;

  function automatic logic [3:0] opcode_of(
    input logic [INSTR_W-1:0] w
  );
    return w[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {word,pc} holding register that catches the
// imem read still in flight when decode stalls.
module fetch_skid_buffer #(
  parameter int AW = 8,
  parameter int IW = 20
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic          clear,
  input  logic [IW-1:0] word_in,
  input  logic [AW-1:0] pc_in,
  output logic          valid,
  output logic [IW-1:0] word,
  output logic [AW-1:0] pc
);

  // clear wins over load so a flush can never keep stale data
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      word  <= '0;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      word  <= word_in;
      pc    <= pc_in;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, drives imem and presents the
// registered IF/ID word to decode with stall and redirect.
module instruction_fetch
  import pipeline_pkg::*;
#(
  parameter int ADDR_WIDTH = PC_W,
  parameter int INSTR_WIDTH = INSTR_W,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  output logic                   instr_valid
);

  fetch_state_t state, state_n;

  logic [ADDR_WIDTH-1:0]  pc, pc_n;
  logic [ADDR_WIDTH-1:0]  req_pc, req_pc_n;
  logic [INSTR_WIDTH-1:0] ins_n;
  logic [ADDR_WIDTH-1:0]  ipc_n;
  logic                   ival_n;

  logic                   skid_load;
  logic                   skid_clear;
  logic                   skid_valid;
  logic [INSTR_WIDTH-1:0] skid_word;
  logic [ADDR_WIDTH-1:0]  skid_pc;

  assign imem_addr = pc;

  fetch_skid_buffer #(
    .AW(ADDR_WIDTH),
    .IW(INSTR_WIDTH)
  ) u_skid (
    .clock   (clock),
    .reset   (reset),
    .load    (skid_load),
    .clear   (skid_clear),
    .word_in (imem_rdata),
    .pc_in   (req_pc),
    .valid   (skid_valid),
    .word    (skid_word),
    .pc      (skid_pc)
  );

  // fetch FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FETCH_FILL;
    end else begin
      state <= state_n;
    end
  end

  // next state, PC issue, IF/ID next value and skid control
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    req_pc_n   = req_pc;
    ins_n      = instruction;
    ipc_n      = instr_pc;
    ival_n     = instr_valid;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (redirect_valid) begin
      pc_n       = redirect_pc;
      skid_clear = 1'b1;
      ins_n      = NOP_INSTR;
      ipc_n      = '0;
      ival_n     = 1'b0;
      state_n    = FETCH_FILL;
    end else begin
      unique case (state)
        FETCH_FILL: begin
          if (!stall) begin
            req_pc_n = pc;
            pc_n     = pc + ADDR_WIDTH'(1);
            ins_n    = NOP_INSTR;
            ipc_n    = '0;
            ival_n   = 1'b0;
            state_n  = FETCH_RUN;
          end
        end
        FETCH_RUN: begin
          if (!stall) begin
            ins_n    = imem_rdata;
            ipc_n    = req_pc;
            ival_n   = 1'b1;
            req_pc_n = pc;
            pc_n     = pc + ADDR_WIDTH'(1);
          end else begin
            skid_load = 1'b1;
            state_n   = FETCH_HOLD;
          end
        end
        FETCH_HOLD: begin
          if (!stall) begin
            ins_n      = skid_word;
            ipc_n      = skid_pc;
            ival_n     = skid_valid;
            skid_clear = 1'b1;
            req_pc_n   = pc;
            pc_n       = pc + ADDR_WIDTH'(1);
            state_n    = FETCH_RUN;
          end
        end
        default: begin
          state_n = FETCH_FILL;
        end
      endcase
    end
  end

  // PC, in-flight address and IF/ID registers
  always_ff @(posedge clock) begin
    if (reset) begin
      pc          <= RESET_PC;
      req_pc      <= RESET_PC;
      instruction <= NOP_INSTR;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      pc          <= pc_n;
      req_pc      <= req_pc_n;
      instruction <= ins_n;
      instr_pc    <= ipc_n;
      instr_valid <= ival_n;
    end
  end

endmodule
